tlb_access_arbiter: RTL and testbench
=====================================

TLB_ACCESS_ARBITER -- requirements
Module: tlb_access_arbiter

Interface
REQ-001 SHALL have parameter ASID_WIDTH, default 1, meaning the lookup/flush ASID width (1..9).
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, meaning the maximum consecutive maintenance ops while a lookup waits.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports lu0_req_i/lu1_req_i (in, 1), lu0_gnt_o/lu1_gnt_o (out, 1), lu0_vaddr_i/lu1_vaddr_i (in, 32) and lu0_asid_i/lu1_asid_i (in, ASID_WIDTH), meaning the instruction (0) and data (1) lookup requesters.
REQ-006 SHALL have ports rsp_valid_o (out, 1), rsp_id_o (out, 1), rsp_hit_o (out, 1), rsp_is_4M_o (out, 1) and rsp_content_o (out, 32), meaning the registered lookup response.
REQ-007 SHALL have ports upd_valid_i (in, 1), upd_ready_o (out, 1), upd_is_4M_i (in, 1), upd_vpn_i (in, 20), upd_asid_i (in, ASID_WIDTH) and upd_content_i (in, 32), meaning the PTW refill.
REQ-008 SHALL have ports flush_req_i (in, 1), flush_ack_o (out, 1), flush_asid_i (in, ASID_WIDTH) and flush_vaddr_i (in, 32), meaning the CSR/sfence flush.
REQ-009 SHALL have TLB-side ports tlb_flush_o (1), tlb_update_o (63), tlb_lu_access_o (1), tlb_lu_asid_o (ASID_WIDTH), tlb_lu_vaddr_o (32), tlb_asid_to_be_flushed_o (ASID_WIDTH) and tlb_vaddr_to_be_flushed_o (32), all outputs.
REQ-010 SHALL have TLB-side ports tlb_lu_hit_i (1), tlb_lu_is_4M_i (1) and tlb_lu_content_i (32), all inputs.

Function
REQ-011 SHALL issue exactly one TLB operation per cycle: FLUSH, UPDATE, LOOKUP or none.
REQ-012 SHALL select by priority FLUSH > UPDATE > LOOKUP, except when REQ-015 applies.
REQ-013 SHALL pack tlb_update_o as {valid, is_4M, vpn[19:0], asid zero-extended to 9 bits, content[31:0]} and drive it to all-zero when no UPDATE is issued.
REQ-014 SHALL arbitrate lookups round-robin: on simultaneous requests grant the requester not granted last; the pointer resets to favour lu0.
REQ-015 SHALL count consecutive FLUSH/UPDATE cycles during which any lu*_req_i is high; at STARVE_LIMIT, force a LOOKUP grant that cycle; the counter clears on any lookup grant.
REQ-016 SHALL make gnt/ack/ready combinational in the issue cycle; requesters hold their request until granted.
REQ-017 SHALL insert one SETTLE bubble after every FLUSH or UPDATE, with no lookup grant; FLUSH/UPDATE are still allowed in the bubble.
REQ-018 SHALL have states IDLE, SETTLE: IDLE->SETTLE on FLUSH/UPDATE issue; SETTLE->IDLE unless another FLUSH/UPDATE is issued.
REQ-019 SHALL register rsp_* from tlb_lu_*_i and the granted id at the grant edge; rsp_valid_o is high for exactly one cycle, one cycle after the grant.
REQ-020 SHALL hold rsp_content_o etc. at their last values when rsp_valid_o is low.
REQ-021 SHALL drive tlb_lu_access_o only in a LOOKUP cycle and zero the TLB address/ASID fields of unused operations.

Reset
REQ-022 SHALL, while rst_i is high, force state IDLE, round-robin pointer to lu0, starvation counter 0 and every *_o to 0, suppressing any in-flight response.
REQ-023 SHALL issue no grant, ack or ready in any cycle where rst_i is high.

Structure
REQ-024 SHALL place the op enum, the state enum, the tlb_update_o field layout/widths and the STARVE_LIMIT default in package tlb_arb_pkg.
REQ-025 SHALL implement lookup selection in one sub-module, rr_arbiter_2.

Verification
REQ-026 lu0 and lu1 both request every cycle for 6 cycles -> grants alternate lu0,lu1,lu0,…; each rsp_id_o matches one cycle later.
REQ-027 flush_req_i and upd_valid_i raised together with lu0_req_i -> cycle0 flush_ack_o=1; cycle1 upd_ready_o=1 (SETTLE); cycle2 SETTLE; cycle3 lu0_gnt_o=1.
REQ-028 Update vpn=0x12345, content=0xA5A5A5A5, followed by a lu0 lookup of vaddr 0x12345000 -> lookup granted no earlier than 2 cycles later; rsp_hit_o=1 and rsp_content_o=0xA5A5A5A5.
REQ-029 upd_valid_i held high continuously with lu1_req_i high -> lu1 is granted after 3 updates (STARVE_LIMIT=3) and then updates resume.
REQ-030 rst_i asserted in the cycle after a lu0 grant -> rsp_valid_o stays 0; all outputs are 0 the next cycle; after release the first grant goes to lu0.

Source files
------------

// File: rtl/tlb_access_arbiter_pkg.sv
// Shared types for the TLB access arbiter: operation/state encodings and the
// refill word layout presented to the TLB array.
package tlb_arb_pkg;

  localparam int STARVE_LIMIT_DEF = 3;

  localparam int UPD_VPN_W     = 20;
  localparam int UPD_ASID_W    = 9;
  localparam int UPD_CONTENT_W = 32;
  localparam int UPD_W         = 1 + 1 + UPD_VPN_W + UPD_ASID_W + UPD_CONTENT_W;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_FLUSH,
    OP_UPDATE,
    OP_LOOKUP
  } tlb_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_SETTLE
  } arb_state_e;

  typedef struct packed {
    logic                     valid;
    logic                     is_4m;
    logic [UPD_VPN_W-1:0]     vpn;
    logic [UPD_ASID_W-1:0]    asid;
    logic [UPD_CONTENT_W-1:0] content;
  } tlb_update_t;

endpackage

// File: rtl/tlb_access_arbiter_if.sv
// Bundle of requester, refill, flush and TLB-array signals around the arbiter.
interface tlb_access_arbiter_if #(
  parameter int ASID_WIDTH = 1
);
  import tlb_arb_pkg::*;

  logic                  lu0_req_i, lu1_req_i;
  logic                  lu0_gnt_o, lu1_gnt_o;
  logic [31:0]           lu0_vaddr_i, lu1_vaddr_i;
  logic [ASID_WIDTH-1:0] lu0_asid_i, lu1_asid_i;

  logic                  rsp_valid_o, rsp_id_o, rsp_hit_o, rsp_is_4M_o;
  logic [31:0]           rsp_content_o;

  logic                  upd_valid_i, upd_ready_o, upd_is_4M_i;
  logic [19:0]           upd_vpn_i;
  logic [ASID_WIDTH-1:0] upd_asid_i;
  logic [31:0]           upd_content_i;

  logic                  flush_req_i, flush_ack_o;
  logic [ASID_WIDTH-1:0] flush_asid_i;
  logic [31:0]           flush_vaddr_i;

  logic                  tlb_flush_o;
  logic [UPD_W-1:0]      tlb_update_o;
  logic                  tlb_lu_access_o;
  logic [ASID_WIDTH-1:0] tlb_lu_asid_o;
  logic [31:0]           tlb_lu_vaddr_o;
  logic [ASID_WIDTH-1:0] tlb_asid_to_be_flushed_o;
  logic [31:0]           tlb_vaddr_to_be_flushed_o;
  logic                  tlb_lu_hit_i, tlb_lu_is_4M_i;
  logic [31:0]           tlb_lu_content_i;

  modport slave (
    input  lu0_req_i, lu1_req_i, lu0_vaddr_i, lu1_vaddr_i, lu0_asid_i, lu1_asid_i,
    input  upd_valid_i, upd_is_4M_i, upd_vpn_i, upd_asid_i, upd_content_i,
    input  flush_req_i, flush_asid_i, flush_vaddr_i,
    input  tlb_lu_hit_i, tlb_lu_is_4M_i, tlb_lu_content_i,
    output lu0_gnt_o, lu1_gnt_o,
    output rsp_valid_o, rsp_id_o, rsp_hit_o, rsp_is_4M_o, rsp_content_o,
    output upd_ready_o, flush_ack_o,
    output tlb_flush_o, tlb_update_o, tlb_lu_access_o, tlb_lu_asid_o, tlb_lu_vaddr_o,
    output tlb_asid_to_be_flushed_o, tlb_vaddr_to_be_flushed_o
  );

  modport master (
    output lu0_req_i, lu1_req_i, lu0_vaddr_i, lu1_vaddr_i, lu0_asid_i, lu1_asid_i,
    output upd_valid_i, upd_is_4M_i, upd_vpn_i, upd_asid_i, upd_content_i,
    output flush_req_i, flush_asid_i, flush_vaddr_i,
    output tlb_lu_hit_i, tlb_lu_is_4M_i, tlb_lu_content_i,
    input  lu0_gnt_o, lu1_gnt_o,
    input  rsp_valid_o, rsp_id_o, rsp_hit_o, rsp_is_4M_o, rsp_content_o,
    input  upd_ready_o, flush_ack_o,
    input  tlb_flush_o, tlb_update_o, tlb_lu_access_o, tlb_lu_asid_o, tlb_lu_vaddr_o,
    input  tlb_asid_to_be_flushed_o, tlb_vaddr_to_be_flushed_o
  );

endinterface

// File: rtl/tlb_access_arbiter_rr.sv
// Two-way round-robin pick between the instruction (0) and data (1) lookups.
module rr_arbiter_2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic       win_o
);

  logic last_q;

  // On a tie the side that did not win last time goes; reset leaves lu0 favoured.
  assign win_o = req_i[1] & (~req_i[0] | ~last_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (adv_i) begin
      last_q <= win_o;
    end
  end

endmodule

// File: rtl/tlb_access_arbiter.sv
// Picks one TLB operation per cycle from flush, refill and two lookup ports.
//   state     | meaning
//   ST_IDLE   | lookups may be granted
//   ST_SETTLE | bubble after a flush/update; no lookup unless starvation forces one
module tlb_access_arbiter
  import tlb_arb_pkg::*;
#(
  parameter int ASID_WIDTH   = 1,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic                clk_i,
  input logic                rst_i,
  tlb_access_arbiter_if.slave bus
);

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  tlb_op_e          op;
  logic [CNT_W-1:0] starve_q;
  logic             any_lu, force_lu, lu_grant, maint_op, win_id;
  logic             rsp_valid_q, rsp_id_q, rsp_hit_q, rsp_is_4m_q;
  logic [31:0]      rsp_content_q;
  tlb_update_t      upd_pkt;

  assign any_lu   = bus.lu0_req_i | bus.lu1_req_i;
  assign force_lu = any_lu && (starve_q == LIMIT);
  assign lu_grant = (op == OP_LOOKUP);
  assign maint_op = (op == OP_FLUSH) || (op == OP_UPDATE);

  rr_arbiter_2 u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i ({bus.lu1_req_i, bus.lu0_req_i}),
    .adv_i (lu_grant),
    .win_o (win_id)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A starving lookup outranks both maintenance ops and the settle bubble.
  always_comb begin
    op      = OP_NONE;
    state_d = ST_IDLE;
    if (!rst_i) begin
      if (force_lu)                          op = OP_LOOKUP;
      else if (bus.flush_req_i)              op = OP_FLUSH;
      else if (bus.upd_valid_i)              op = OP_UPDATE;
      else if (any_lu && state_q == ST_IDLE) op = OP_LOOKUP;
      if (op == OP_FLUSH || op == OP_UPDATE) state_d = ST_SETTLE;
    end
  end

  always_comb begin
    upd_pkt = '0;
    if (op == OP_UPDATE) begin
      upd_pkt.valid                = 1'b1;
      upd_pkt.is_4m                = bus.upd_is_4M_i;
      upd_pkt.vpn                  = bus.upd_vpn_i;
      upd_pkt.asid[ASID_WIDTH-1:0] = bus.upd_asid_i;
      upd_pkt.content              = bus.upd_content_i;
    end
  end

  assign bus.tlb_update_o              = upd_pkt;
  assign bus.upd_ready_o               = (op == OP_UPDATE);
  assign bus.flush_ack_o               = (op == OP_FLUSH);
  assign bus.tlb_flush_o               = (op == OP_FLUSH);
  assign bus.tlb_asid_to_be_flushed_o  = (op == OP_FLUSH) ? bus.flush_asid_i  : '0;
  assign bus.tlb_vaddr_to_be_flushed_o = (op == OP_FLUSH) ? bus.flush_vaddr_i : '0;

  assign bus.lu0_gnt_o       = lu_grant & ~win_id;
  assign bus.lu1_gnt_o       = lu_grant &  win_id;
  assign bus.tlb_lu_access_o = lu_grant;
  assign bus.tlb_lu_asid_o   = !lu_grant ? '0 : (win_id ? bus.lu1_asid_i  : bus.lu0_asid_i);
  assign bus.tlb_lu_vaddr_o  = !lu_grant ? '0 : (win_id ? bus.lu1_vaddr_i : bus.lu0_vaddr_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_is_4m_q   <= 1'b0;
      rsp_content_q <= '0;
    end else begin
      if (lu_grant) begin
        starve_q <= '0;
      end else if (maint_op && any_lu && starve_q != LIMIT) begin
        starve_q <= starve_q + 1'b1;
      end
      rsp_valid_q <= lu_grant;
      if (lu_grant) begin
        rsp_id_q      <= win_id;
        rsp_hit_q     <= bus.tlb_lu_hit_i;
        rsp_is_4m_q   <= bus.tlb_lu_is_4M_i;
        rsp_content_q <= bus.tlb_lu_content_i;
      end
    end
  end

  // Reset masks the response immediately so an in-flight result never escapes.
  assign bus.rsp_valid_o   = rsp_valid_q & ~rst_i;
  assign bus.rsp_id_o      = rsp_id_q    & ~rst_i;
  assign bus.rsp_hit_o     = rsp_hit_q   & ~rst_i;
  assign bus.rsp_is_4M_o   = rsp_is_4m_q & ~rst_i;
  assign bus.rsp_content_o = rst_i ? '0 : rsp_content_q;

endmodule

// File: tb/tb_tlb_access_arbiter.sv
// Bench for tlb_access_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a rule-level model and a small TLB array stand-in.
module tb_tlb_access_arbiter;
  import tlb_arb_pkg::*;

  localparam int AW  = 1;
  localparam int LIM = 3;
  localparam int NE  = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  tlb_access_arbiter_if #(.ASID_WIDTH(AW)) bus ();

  tlb_access_arbiter #(.ASID_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // TLB array stand-in: entries written from tlb_update_o, all cleared by a flush.
  logic        e_v   [NE];
  logic        e_4m  [NE];
  logic [19:0] e_vpn [NE];
  logic [8:0]  e_asid[NE];
  logic [31:0] e_c   [NE];
  int          wp = 0;

  function automatic logic [33:0] tlb_find(input logic [31:0] va, input logic [8:0] as);
    logic [33:0] r;
    r = '0;
    for (int i = 0; i < NE; i++)
      if (e_v[i] && e_asid[i] == as &&
          (e_4m[i] ? (e_vpn[i][19:10] == va[31:22]) : (e_vpn[i] == va[31:12])))
        r = {1'b1, e_4m[i], e_c[i]};
    return r;
  endfunction

  always @(negedge clk) begin
    logic [33:0] r;
    r = tlb_find(bus.tlb_lu_vaddr_o, 9'(bus.tlb_lu_asid_o));
    bus.tlb_lu_hit_i     = r[33];
    bus.tlb_lu_is_4M_i   = r[32];
    bus.tlb_lu_content_i = r[31:0];
    if (bus.tlb_flush_o === 1'b1)
      for (int i = 0; i < NE; i++) e_v[i] = 1'b0;
    if (bus.tlb_update_o[62] === 1'b1) begin
      e_v[wp]    = 1'b1;
      e_4m[wp]   = bus.tlb_update_o[61];
      e_vpn[wp]  = bus.tlb_update_o[60:41];
      e_asid[wp] = bus.tlb_update_o[40:32];
      e_c[wp]    = bus.tlb_update_o[31:0];
      wp         = (wp + 1) % NE;
    end
  end

  // Reference model: which operation the rules pick this cycle, and what the
  // registered response must show. m_last = 1 means lu0 wins the next tie.
  int          m_last = 1;
  int          m_starve = 0;
  bit          m_settle = 0;
  bit          r_v = 0, r_id = 0, r_hit = 0, r_4m = 0;
  logic [31:0] r_c = '0;
  bit          x_g0 = 0, x_g1 = 0, x_ack = 0, x_rdy = 0;

  always @(negedge clk) begin
    int              op;   // 0 none, 1 flush, 2 update, 3 lookup
    int              win;
    bit              any_req;
    logic [31:0]     xva, xfv;
    logic [AW-1:0]   xas, xfa;
    logic [62:0]     xu;
    logic [33:0]     res;
    op = 0; win = 0;
    any_req = bus.lu0_req_i | bus.lu1_req_i;
    if (!rst) begin
      if (any_req && m_starve >= LIM) op = 3;
      else if (bus.flush_req_i)       op = 1;
      else if (bus.upd_valid_i)       op = 2;
      else if (any_req && !m_settle)  op = 3;
      if (op == 3)
        win = (bus.lu0_req_i && bus.lu1_req_i) ? 1 - m_last : (bus.lu0_req_i ? 0 : 1);
    end
    x_g0 = (op == 3 && win == 0);
    x_g1 = (op == 3 && win == 1);
    x_ack = (op == 1);
    x_rdy = (op == 2);
    xva = (op == 3) ? (win == 1 ? bus.lu1_vaddr_i : bus.lu0_vaddr_i) : 32'h0;
    xas = (op == 3) ? (win == 1 ? bus.lu1_asid_i  : bus.lu0_asid_i)  : '0;
    xfv = (op == 1) ? bus.flush_vaddr_i : 32'h0;
    xfa = (op == 1) ? bus.flush_asid_i  : '0;
    xu  = (op == 2) ? {1'b1, bus.upd_is_4M_i, bus.upd_vpn_i, 9'(bus.upd_asid_i), bus.upd_content_i} : 63'h0;

    chk("handshake", {bus.lu0_gnt_o, bus.lu1_gnt_o, bus.flush_ack_o, bus.upd_ready_o},
        {x_g0, x_g1, x_ack, x_rdy});
    chk("lookup_side", {bus.tlb_lu_access_o, bus.tlb_lu_asid_o, bus.tlb_lu_vaddr_o},
        {op == 3, xas, xva});
    chk("flush_side", {bus.tlb_flush_o, bus.tlb_asid_to_be_flushed_o, bus.tlb_vaddr_to_be_flushed_o},
        {op == 1, xfa, xfv});
    chk("update_word", bus.tlb_update_o, xu);
    chk("response", {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_hit_o, bus.rsp_is_4M_o, bus.rsp_content_o},
        rst ? 36'h0 : {r_v, r_id, r_hit, r_4m, r_c});

    if (rst) begin
      m_last = 1; m_starve = 0; m_settle = 0;
      r_v = 0; r_id = 0; r_hit = 0; r_4m = 0; r_c = '0;
    end else begin
      m_settle = (op == 1 || op == 2);
      r_v = (op == 3);
      if (op == 3) begin
        res = tlb_find(xva, 9'(xas));
        r_id = (win == 1); r_hit = res[33]; r_4m = res[32]; r_c = res[31:0];
        m_last = win; m_starve = 0;
      end else if ((op == 1 || op == 2) && any_req) begin
        m_starve++;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr_in();
    bus.lu0_req_i = 0; bus.lu1_req_i = 0;
    bus.lu0_vaddr_i = '0; bus.lu1_vaddr_i = '0; bus.lu0_asid_i = '0; bus.lu1_asid_i = '0;
    bus.upd_valid_i = 0; bus.upd_is_4M_i = 0; bus.upd_vpn_i = '0; bus.upd_asid_i = '0;
    bus.upd_content_i = '0;
    bus.flush_req_i = 0; bus.flush_asid_i = '0; bus.flush_vaddr_i = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsp"}, {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_hit_o, bus.rsp_is_4M_o, bus.rsp_content_o}, 0);
    chk({tag, "_upd"}, bus.tlb_update_o, 0);
    chk({tag, "_ctl"}, {bus.lu0_gnt_o, bus.lu1_gnt_o, bus.upd_ready_o, bus.flush_ack_o, bus.tlb_flush_o,
                        bus.tlb_lu_access_o, bus.tlb_lu_asid_o, bus.tlb_lu_vaddr_o}, 0);
    chk({tag, "_fl"}, {bus.tlb_asid_to_be_flushed_o, bus.tlb_vaddr_to_be_flushed_o}, 0);
  endtask

  function automatic logic [31:0] rnd_va();
    return {12'h001, 8'($urandom_range(0, 7)), 12'($urandom)};
  endfunction

  task automatic rnd_drive(input int c);
    int pu;
    pu = ((c / 400) % 2 == 1) ? 85 : 25;
    rst = ($urandom_range(0, 249) == 0);
    if (!bus.lu0_req_i || x_g0) begin
      bus.lu0_req_i   = ($urandom_range(0, 99) < 45);
      bus.lu0_vaddr_i = rnd_va();
      bus.lu0_asid_i  = AW'($urandom_range(0, 1));
    end
    if (!bus.lu1_req_i || x_g1) begin
      bus.lu1_req_i   = ($urandom_range(0, 99) < 45);
      bus.lu1_vaddr_i = rnd_va();
      bus.lu1_asid_i  = AW'($urandom_range(0, 1));
    end
    if (!bus.upd_valid_i || x_rdy) begin
      bus.upd_valid_i   = ($urandom_range(0, 99) < pu);
      bus.upd_is_4M_i   = ($urandom_range(0, 3) == 0);
      bus.upd_vpn_i     = {12'h001, 8'($urandom_range(0, 7))};
      bus.upd_asid_i    = AW'($urandom_range(0, 1));
      bus.upd_content_i = $urandom;
    end
    if (!bus.flush_req_i || x_ack) begin
      bus.flush_req_i   = ($urandom_range(0, 99) < 5);
      bus.flush_asid_i  = AW'($urandom_range(0, 1));
      bus.flush_vaddr_i = $urandom;
    end
  endtask

  initial begin
    for (int i = 0; i < NE; i++) begin
      e_v[i] = 0; e_4m[i] = 0; e_vpn[i] = '0; e_asid[i] = '0; e_c[i] = '0;
    end
    bus.tlb_lu_hit_i = 0; bus.tlb_lu_is_4M_i = 0; bus.tlb_lu_content_i = '0;
    rst = 1;
    clr_in();

    // Reset: no handshakes even with everything requesting.
    nxt(); smp();
    chk_all_zero("reset");
    nxt(); bus.lu0_req_i = 1; bus.flush_req_i = 1; bus.upd_valid_i = 1;
    smp();
    chk("reset_no_grant", {bus.lu0_gnt_o, bus.flush_ack_o, bus.upd_ready_o, bus.tlb_flush_o}, 4'b0000);

    // Both lookups every cycle: lu0, lu1, lu0, ... with id echoed one cycle later.
    nxt(); rst = 0; clr_in();
    bus.lu0_req_i = 1; bus.lu1_req_i = 1;
    bus.lu0_vaddr_i = 32'h0010_1000; bus.lu1_vaddr_i = 32'h0010_2000;
    for (int k = 0; k < 6; k++) begin
      smp();
      chk("rr_gnt", {bus.lu0_gnt_o, bus.lu1_gnt_o}, {k % 2 == 0, k % 2 == 1});
      if (k > 0) chk("rr_rsp_id", {bus.rsp_valid_o, bus.rsp_id_o}, {1'b1, (k % 2 == 0)});
      nxt();
    end
    bus.lu0_req_i = 0; bus.lu1_req_i = 0;
    smp();
    chk("rr_rsp_last", {bus.rsp_valid_o, bus.rsp_id_o}, 2'b11);
    nxt(); smp();

    // Flush + update + lookup together: flush, update in bubble, bubble, lookup.
    nxt();
    bus.flush_req_i = 1; bus.upd_valid_i = 1; bus.lu0_req_i = 1;
    bus.upd_vpn_i = 20'h00777; bus.upd_content_i = 32'h1111_1111;
    smp(); chk("prio_c0", {bus.flush_ack_o, bus.upd_ready_o, bus.lu0_gnt_o}, 3'b100);
    nxt(); bus.flush_req_i = 0;
    smp(); chk("prio_c1", {bus.flush_ack_o, bus.upd_ready_o, bus.lu0_gnt_o}, 3'b010);
    nxt(); bus.upd_valid_i = 0;
    smp(); chk("prio_c2", {bus.flush_ack_o, bus.upd_ready_o, bus.lu0_gnt_o}, 3'b000);
    nxt();
    smp(); chk("prio_c3", {bus.flush_ack_o, bus.upd_ready_o, bus.lu0_gnt_o}, 3'b001);
    nxt(); bus.lu0_req_i = 0;
    smp();

    // Refill then lookup of the same page hits with the refilled content.
    nxt();
    bus.upd_valid_i = 1; bus.upd_vpn_i = 20'h12345; bus.upd_content_i = 32'hA5A5_A5A5;
    bus.upd_is_4M_i = 0; bus.upd_asid_i = '0;
    bus.lu0_req_i = 1; bus.lu0_vaddr_i = 32'h1234_5000; bus.lu0_asid_i = '0;
    smp(); chk("refill_issue", {bus.upd_ready_o, bus.lu0_gnt_o}, 2'b10);
    nxt(); bus.upd_valid_i = 0;
    smp(); chk("refill_settle", bus.lu0_gnt_o, 1'b0);
    nxt();
    smp(); chk("refill_lookup", bus.lu0_gnt_o, 1'b1);
    nxt(); bus.lu0_req_i = 0;
    smp();
    chk("refill_hit", {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_hit_o, bus.rsp_is_4M_o, bus.rsp_content_o},
        {4'b1010, 32'hA5A5_A5A5});

    // Continuous refills starve lu1 for exactly three ops.
    nxt();
    bus.upd_valid_i = 1; bus.upd_vpn_i = 20'h00100;
    bus.lu1_req_i = 1; bus.lu1_vaddr_i = 32'h0010_0000;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("starve_rdy", bus.upd_ready_o, k != 3);
      chk("starve_gnt1", bus.lu1_gnt_o, k == 3);
      nxt();
      bus.upd_vpn_i = 20'h00101 + 20'(k);
      if (k == 3) bus.lu1_req_i = 0;
    end
    bus.upd_valid_i = 0;
    smp();
    nxt(); smp();

    // Reset right after a lu0 grant kills the response and rewinds the pointer.
    nxt(); bus.lu0_req_i = 1;
    smp(); chk("pre_rst_gnt", bus.lu0_gnt_o, 1'b1);
    nxt(); bus.lu0_req_i = 0; rst = 1;
    smp(); chk_all_zero("in_rst");
    nxt(); rst = 0;
    smp(); chk_all_zero("post_rst");
    nxt(); bus.lu0_req_i = 1; bus.lu1_req_i = 1;
    smp(); chk("post_rst_rr", {bus.lu0_gnt_o, bus.lu1_gnt_o}, 2'b10);
    nxt(); bus.lu0_req_i = 0;
    smp(); chk("post_rst_lu1", bus.lu1_gnt_o, 1'b1);
    nxt(); bus.lu1_req_i = 0;
    smp();

    for (int c = 0; c < 3000; c++) begin
      nxt();
      rnd_drive(c);
    end
    nxt(); rst = 0; clr_in();
    smp();
    nxt(); smp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
